// File: rtl/test_card_pattern_pkg.sv
// Shared definitions for the test card generator: pattern mode codes and the
// bouncing-square direction state.
package test_card_pattern_pkg;

  localparam logic [2:0] MODE_BORDER = 3'd0;
  localparam logic [2:0] MODE_BARS   = 3'd1;
  localparam logic [2:0] MODE_CHECK  = 3'd2;
  localparam logic [2:0] MODE_GRAD   = 3'd3;
  localparam logic [2:0] MODE_SQUARE = 3'd4;

  typedef enum logic {
    DirPos = 1'b0,
    DirNeg = 1'b1
  } dir_e;

endpackage

// File: rtl/test_card_pattern_bounce_axis.sv
// One axis of the bouncing square: position register plus direction FSM,
// advanced once per frame and clamped so the square stays fully on screen.
module test_card_pattern_bounce_axis
  import test_card_pattern_pkg::*;
#(
  parameter int unsigned RES   = 640,
  parameter int unsigned SIZE  = 32,
  parameter int unsigned SPEED = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_step,
  output logic [15:0] o_pos
);

  localparam logic [15:0] PosMax = 16'(RES - SIZE);
  // p + SIZE + SPEED > RES rewritten as p > RES - SIZE - SPEED to avoid overflow.
  localparam logic [15:0] Thresh = 16'(RES - SIZE - SPEED);
  localparam logic [15:0] Step   = 16'(SPEED);

  logic [15:0] pos_q, pos_d;
  dir_e        dir_q, dir_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pos_q <= '0;
      dir_q <= DirPos;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (i_step) begin
      unique case (dir_q)
        DirPos: begin
          if (pos_q > Thresh) begin
            pos_d = PosMax;
            dir_d = DirNeg;
          end else begin
            pos_d = pos_q + Step;
          end
        end
        DirNeg: begin
          if (pos_q < Step) begin
            pos_d = '0;
            dir_d = DirPos;
          end else begin
            pos_d = pos_q - Step;
          end
        end
        default: begin
          pos_d = '0;
          dir_d = DirPos;
        end
      endcase
    end
  end

  assign o_pos = pos_q;

endmodule

// File: rtl/test_card_pattern.sv
// Mode-selectable test card generator: borders, colour bars, checkerboard,
// animated gradient and bouncing square, with registered RGB output.
module test_card_pattern
  import test_card_pattern_pkg::*;
#(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned BW       = 16,
  parameter int unsigned CW       = 8,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned SQ_SIZE  = 32,
  parameter int unsigned SQ_SPEED = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   i_x,
  input  logic [15:0]   i_y,
  input  logic          i_frame,
  input  logic [2:0]    i_mode,
  output logic [CW-1:0] o_red,
  output logic [CW-1:0] o_green,
  output logic [CW-1:0] o_blue,
  output logic [2:0]    o_mode
);

  localparam logic [15:0]   HRes    = 16'(H_RES);
  localparam logic [15:0]   VRes    = 16'(V_RES);
  localparam logic [15:0]   Bw      = 16'(BW);
  localparam logic [15:0]   RightX  = 16'(H_RES - BW);
  localparam logic [15:0]   BottomY = 16'(V_RES - BW);
  localparam int unsigned   BarW    = H_RES / 8;
  localparam logic [16:0]   SqSize  = 17'(SQ_SIZE);
  localparam logic [CW-1:0] Fill    = {CW{1'b1}};
  localparam logic [CW-1:0] BgBlue  = CW'(1) << (CW - 2);

  logic [2:0]    mode_q;
  logic [CW-1:0] frame_q;
  logic [CW-1:0] red_q, green_q, blue_q;
  logic [CW-1:0] red_d, green_d, blue_d;
  logic [15:0]   sq_x, sq_y;
  logic [2:0]    bar;
  logic          active, left, right, top, bottom, chk, in_sq;

  test_card_pattern_bounce_axis #(
    .RES   (H_RES),
    .SIZE  (SQ_SIZE),
    .SPEED (SQ_SPEED)
  ) u_axis_x (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_step (i_frame),
    .o_pos  (sq_x)
  );

  test_card_pattern_bounce_axis #(
    .RES   (V_RES),
    .SIZE  (SQ_SIZE),
    .SPEED (SQ_SPEED)
  ) u_axis_y (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_step (i_frame),
    .o_pos  (sq_y)
  );

  assign active = (i_x < HRes) && (i_y < VRes);
  assign left   = i_x < Bw;
  assign right  = i_x >= RightX;
  assign top    = i_y < Bw;
  assign bottom = i_y >= BottomY;
  assign chk    = i_x[CHK_LOG2] ^ i_y[CHK_LOG2];
  assign in_sq  = ({1'b0, i_x} >= {1'b0, sq_x}) && ({1'b0, i_x} < {1'b0, sq_x} + SqSize) &&
                  ({1'b0, i_y} >= {1'b0, sq_y}) && ({1'b0, i_y} < {1'b0, sq_y} + SqSize);

  // Comparator chain instead of a divider; leftover pixels fall into bar 7.
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (i_x >= 16'(k * BarW)) bar = 3'(k);
    end
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      case (mode_q)
        MODE_BORDER: begin
          red_d   = {CW{left | top}};
          green_d = {CW{bottom | top}};
          blue_d  = {CW{right | top}};
        end
        MODE_BARS: begin
          red_d   = {CW{~bar[1]}};
          green_d = {CW{~bar[2]}};
          blue_d  = {CW{~bar[0]}};
        end
        MODE_CHECK: begin
          red_d   = {CW{chk}};
          green_d = {CW{chk}};
          blue_d  = {CW{chk}};
        end
        MODE_GRAD: begin
          red_d   = i_x[CW-1:0];
          green_d = i_y[CW-1:0];
          blue_d  = frame_q;
        end
        MODE_SQUARE: begin
          red_d   = in_sq ? Fill : '0;
          green_d = in_sq ? Fill : '0;
          blue_d  = in_sq ? Fill : BgBlue;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q  <= MODE_BORDER;
      frame_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      if (i_frame) begin
        mode_q  <= i_mode;
        frame_q <= frame_q + CW'(1);
      end
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_red   = red_q;
  assign o_green = green_q;
  assign o_blue  = blue_q;
  assign o_mode  = mode_q;

endmodule

// File: tb/tb_test_card_pattern.sv
// Directed bench for test_card_pattern at default parameters (640x480, CW=8).
module tb_test_card_pattern;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, y;
  logic        frame;
  logic [2:0]  mode;
  logic [7:0]  red, green, blue;
  logic [2:0]  om;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state for the frame counter and bouncing square.
  int frames_m;
  int sqx, sqy;
  bit negx, negy;

  always #5 clk = ~clk;

  test_card_pattern dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_x     (x),
    .i_y     (y),
    .i_frame (frame),
    .i_mode  (mode),
    .o_red   (red),
    .o_green (green),
    .o_blue  (blue),
    .o_mode  (om)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int xi, input int yi);
    x = 16'(xi);
    y = 16'(yi);
    cyc();
  endtask

  task automatic model_reset();
    frames_m = 0;
    sqx = 0; sqy = 0; negx = 0; negy = 0;
  endtask

  task automatic model_step(inout int p, inout bit neg, input int res);
    if (!neg) begin
      if (p + 32 + 2 > res) begin p = res - 32; neg = 1; end
      else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; neg = 0; end
      else p = p - 2;
    end
  endtask

  task automatic pulse_at(input logic [2:0] m, input int xi, input int yi);
    frame = 1'b1;
    mode  = m;
    px(xi, yi);
    frame = 1'b0;
    frames_m++;
    model_step(sqx, negx, 640);
    model_step(sqy, negy, 480);
  endtask

  task automatic pulse(input logic [2:0] m);
    pulse_at(m, 700, 700);
  endtask

  task automatic test_reset();
    int tx[6]; int ty[6]; logic [23:0] te[6];
    rst = 1'b1; frame = 1'b0; mode = 3'd0;
    px(5, 5);
    n_cmp++;
    if ({red, green, blue, om} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_out: got rgb=%h mode=%0d want rgb=000000 mode=0", {red, green, blue}, om);
    end
    rst = 1'b0;
    model_reset();
    tx = '{5, 5, 634, 100, 100, 639};
    ty = '{5, 100, 100, 470, 100, 479};
    te = '{24'hFFFFFF, 24'hFF0000, 24'h0000FF, 24'h00FF00, 24'h000000, 24'h00FFFF};
    for (int i = 0; i < 6; i++) begin
      px(tx[i], ty[i]);
      n_cmp++;
      if ({red, green, blue} !== te[i]) begin
        n_bad++;
        $display("FAIL border(%0d,%0d): got %h want %h", tx[i], ty[i], {red, green, blue}, te[i]);
      end
    end
  endtask

  task automatic test_mode_latch();
    int tx[7]; logic [23:0] te[7];
    mode = 3'd1;
    px(80, 100);
    px(80, 100);
    n_cmp++;
    if (om !== 3'd0 || {red, green, blue} !== 24'h0) begin
      n_bad++;
      $display("FAIL mode_no_frame: got mode=%0d rgb=%h want mode=0 rgb=000000", om, {red, green, blue});
    end
    pulse(3'd1);
    mode = 3'd5;  // ignored without a frame pulse
    n_cmp++;
    if (om !== 3'd1) begin
      n_bad++;
      $display("FAIL mode_latch: got %0d want 1", om);
    end
    tx = '{80, 639, 0, 400, 559, 560, 160};
    te = '{24'hFFFF00, 24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h00FFFF};
    for (int i = 0; i < 7; i++) begin
      px(tx[i], 100);
      n_cmp++;
      if ({red, green, blue} !== te[i]) begin
        n_bad++;
        $display("FAIL bars(x=%0d): got %h want %h", tx[i], {red, green, blue}, te[i]);
      end
    end
  endtask

  task automatic test_frame_edge();
    // Pixel on the pulse cycle must still be drawn as bars (white), not checker (black).
    pulse_at(3'd2, 32, 100);
    n_cmp++;
    if ({red, green, blue} !== 24'hFFFFFF || om !== 3'd2) begin
      n_bad++;
      $display("FAIL frame_edge_old_mode: got rgb=%h mode=%0d want rgb=FFFFFF mode=2", {red, green, blue}, om);
    end
    px(32, 100);
    n_cmp++;
    if ({red, green, blue} !== 24'h000000) begin
      n_bad++;
      $display("FAIL frame_edge_new_mode: got %h want 000000", {red, green, blue});
    end
  endtask

  task automatic test_checker();
    int tx[7]; int ty[7]; logic [23:0] te[7];
    tx = '{0, 32, 32, 700, 0, 31, 63};
    ty = '{0, 0, 32, 10, 32, 31, 0};
    te = '{24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF};
    for (int i = 0; i < 7; i++) begin
      px(tx[i], ty[i]);
      n_cmp++;
      if ({red, green, blue} !== te[i]) begin
        n_bad++;
        $display("FAIL checker(%0d,%0d): got %h want %h", tx[i], ty[i], {red, green, blue}, te[i]);
      end
    end
  endtask

  task automatic test_gradient();
    while (frames_m < 300) pulse(3'd3);
    px(16'h1A5, 16'h0C3);
    n_cmp++;
    if ({red, green, blue} !== 24'hA5C32C) begin
      n_bad++;
      $display("FAIL gradient_300: got %h want A5C32C", {red, green, blue});
    end
    px(16'h1FF, 16'h100);
    n_cmp++;
    if ({red, green, blue} !== 24'hFF002C) begin
      n_bad++;
      $display("FAIL gradient_xy: got %h want FF002C", {red, green, blue});
    end
    pulse(3'd3);
    px(0, 0);
    n_cmp++;
    if ({red, green, blue} !== 24'h00002D) begin
      n_bad++;
      $display("FAIL gradient_301: got %h want 00002D", {red, green, blue});
    end
  endtask

  task automatic test_invalid();
    int tx[4]; int ty[4];
    pulse(3'd6);
    mode = 3'd2;
    n_cmp++;
    if (om !== 3'd6) begin
      n_bad++;
      $display("FAIL invalid_mode: got %0d want 6", om);
    end
    tx = '{0, 5, 320, 639};
    ty = '{0, 5, 240, 479};
    for (int i = 0; i < 4; i++) begin
      px(tx[i], ty[i]);
      n_cmp++;
      if ({red, green, blue} !== 24'h0 || om !== 3'd6) begin
        n_bad++;
        $display("FAIL invalid_rgb(%0d,%0d): got rgb=%h mode=%0d want rgb=000000 mode=6",
                 tx[i], ty[i], {red, green, blue}, om);
      end
    end
  endtask

  task automatic test_square();
    logic [23:0] exp;
    for (int i = 0; i < 700; i++) begin
      pulse(3'd4);
      if (sqx >= 604 || sqx <= 2 || sqy >= 444 || sqy <= 2) begin
        px(sqx, sqy);
        n_cmp++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
          n_bad++;
          $display("FAIL square_tl(%0d,%0d): got %h want FFFFFF", sqx, sqy, {red, green, blue});
        end
        px(sqx + 31, sqy + 31);
        n_cmp++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
          n_bad++;
          $display("FAIL square_br(%0d,%0d): got %h want FFFFFF", sqx, sqy, {red, green, blue});
        end
        exp = (sqx + 32 < 640) ? 24'h000040 : 24'h000000;
        px(sqx + 32, sqy);
        n_cmp++;
        if ({red, green, blue} !== exp) begin
          n_bad++;
          $display("FAIL square_right(%0d,%0d): got %h want %h", sqx, sqy, {red, green, blue}, exp);
        end
        if (sqx > 0) begin
          px(sqx - 1, sqy);
          n_cmp++;
          if ({red, green, blue} !== 24'h000040) begin
            n_bad++;
            $display("FAIL square_left(%0d,%0d): got %h want 000040", sqx, sqy, {red, green, blue});
          end
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    pulse(3'd3);
    rst = 1'b1;
    px(10, 10);
    n_cmp++;
    if ({red, green, blue} !== 24'h0 || om !== 3'd0) begin
      n_bad++;
      $display("FAIL midframe_reset: got rgb=%h mode=%0d want rgb=000000 mode=0", {red, green, blue}, om);
    end
    rst = 1'b0;
    model_reset();
    px(5, 5);
    n_cmp++;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      n_bad++;
      $display("FAIL after_reset_border: got %h want FFFFFF", {red, green, blue});
    end
    pulse(3'd4);
    px(2, 2);
    n_cmp++;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      n_bad++;
      $display("FAIL square_restart_in: got %h want FFFFFF", {red, green, blue});
    end
    px(1, 2);
    n_cmp++;
    if ({red, green, blue} !== 24'h000040) begin
      n_bad++;
      $display("FAIL square_restart_out: got %h want 000040", {red, green, blue});
    end
    pulse(3'd3);
    px(0, 0);
    n_cmp++;
    if ({red, green, blue} !== 24'h000002) begin
      n_bad++;
      $display("FAIL counter_restart: got %h want 000002", {red, green, blue});
    end
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; mode = 3'd0; x = '0; y = '0;
    model_reset();
    test_reset();
    test_mode_latch();
    test_frame_edge();
    test_checker();
    test_gradient();
    test_invalid();
    test_square();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
